result_collector: RTL and testbench

Back-end consumer of the TPU result stream. Accepts the packed 64-bit `result_o`/`result_valid_o` words, each carrying two 32-bit column results. Unpacks them into per-column lanes and reassembles N/2 consecutive words into one N-column output row. Completed rows are buffered in a small row FIFO and presented downstream on a valid/ready handshake. This is the writeback side of the array, feeding the activation buffer or host readout.

---
 rtl/result_collector_pkg.sv | 28 ++
 rtl/result_collector_if.sv | 23 ++
 rtl/result_collector_row_fifo.sv | 48 ++++
 rtl/result_collector.sv | 112 +++++++++++
 tb/tb_result_collector.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/result_collector_pkg.sv
// Shared TPU package: lane width, packed result word layout and the signed clamp
// used when RESULT_COLLECTOR_SAT_EN is compiled in.
package tpu_pkg;

    localparam int PSUM_W = 32;

    typedef struct packed {
        logic [PSUM_W-1:0] lane1;
        logic [PSUM_W-1:0] lane0;
    } result_word_t;

    // Clamp a signed PSUM_W value to the signed out_w-bit range.
    function automatic logic [PSUM_W-1:0] sat_signed(input logic [PSUM_W-1:0] v,
                                                     input int unsigned out_w);
        logic signed [PSUM_W-1:0] hi;
        logic signed [PSUM_W-1:0] lo;
        logic signed [PSUM_W-1:0] sv;
        for (int unsigned i = 0; i < PSUM_W; i++) begin
            hi[i] = (i + 1 < out_w);
        end
        lo = ~hi;
        sv = v;
        if (sv > hi) return hi;
        if (sv < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Result word input stream and assembled row output stream of result_collector.
interface result_collector_if #(
    parameter int N      = 8,
    parameter int PSUM_W = 32,
    parameter int EW     = 32
);
    logic [2*PSUM_W-1:0]   result_i;
    logic                  result_valid_i;
    logic                  flush_i;
    logic [N-1:0][EW-1:0]  row_o;
    logic                  row_valid_o;
    logic                  row_ready_i;

    modport master (
        output result_i, result_valid_i, flush_i, row_ready_i,
        input  row_o, row_valid_o
    );

    modport slave (
        input  result_i, result_valid_i, flush_i, row_ready_i,
        output row_o, row_valid_o
    );
endinterface

// File: rtl/result_collector_row_fifo.sv
// Synchronous row FIFO; the caller only pushes when full if it pops in the same cycle.
module row_fifo #(
    parameter int N     = 8,
    parameter int EW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [N-1:0][EW-1:0] push_row,
    output logic                 full,
    output logic                 empty,
    output logic [N-1:0][EW-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0][EW-1:0] mem [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_row;
    end
endmodule

// File: rtl/result_collector.sv
// Unpacks 2-lane result words into N-column rows and queues them for writeback.
// Define RESULT_COLLECTOR_SAT_EN to clamp lanes to signed OUT_W elements.
module result_collector
    import tpu_pkg::*;
#(
    parameter int N         = 8,
    parameter int PSUM_W    = tpu_pkg::PSUM_W,
    parameter int OUT_W     = 8,
    parameter int ROW_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    result_collector_if.slave    bus,
    output logic                 overflow_o,
    output logic [15:0]          drop_cnt_o
);
`ifdef RESULT_COLLECTOR_SAT_EN
    localparam int EW = OUT_W;
`else
    localparam int EW = PSUM_W;
`endif
    localparam int WORDS = N / 2;
    localparam int WPW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (N < 2 || (N % 2) != 0 || ROW_DEPTH < 1 || OUT_W < 1) begin : g_bad_params
        $error("result_collector: illegal parameter set");
    end

    logic [WPW-1:0]       word_ptr;
    logic [N-1:0][EW-1:0] asm_row;
    logic [N-1:0][EW-1:0] next_row;
    logic [EW-1:0]        lane0;
    logic [EW-1:0]        lane1;
    logic                 accept;
    logic                 complete;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 drop;

    always_comb begin
`ifdef RESULT_COLLECTOR_SAT_EN
        lane0 = EW'(sat_signed(bus.result_i[PSUM_W-1:0], unsigned'(OUT_W)));
        lane1 = EW'(sat_signed(bus.result_i[2*PSUM_W-1:PSUM_W], unsigned'(OUT_W)));
`else
        lane0 = bus.result_i[PSUM_W-1:0];
        lane1 = bus.result_i[2*PSUM_W-1:PSUM_W];
`endif
    end

    // The final word bypasses asm_row so the row is pushed on the edge that samples it.
    always_comb begin
        next_row      = asm_row;
        next_row[N-2] = lane0;
        next_row[N-1] = lane1;
    end

    assign accept    = bus.result_valid_i && !bus.flush_i;
    assign complete  = accept && (word_ptr == WPW'(WORDS - 1));
    assign fifo_pop  = !fifo_empty && bus.row_ready_i;
    assign fifo_push = complete && (!fifo_full || fifo_pop);
    assign drop      = complete && fifo_full && !fifo_pop;

    assign bus.row_valid_o = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_ptr <= '0;
        end else if (bus.flush_i) begin
            word_ptr <= '0;
        end else if (bus.result_valid_i) begin
            word_ptr <= complete ? '0 : word_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned k = 0; k < WORDS; k++) begin
                if (word_ptr == WPW'(k)) begin
                    asm_row[2*k]     <= lane0;
                    asm_row[2*k + 1] <= lane1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    row_fifo #(
        .N     (N),
        .EW    (EW),
        .DEPTH (ROW_DEPTH)
    ) u_row_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .push_row (next_row),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (bus.row_o)
    );
endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: stimulus queues expected rows, a monitor
// compares every row accepted downstream. Honours RESULT_COLLECTOR_SAT_EN.
module tb_result_collector;
    import tpu_pkg::*;

    localparam int N         = 8;
    localparam int OUT_W     = 8;
    localparam int ROW_DEPTH = 2;
`ifdef RESULT_COLLECTOR_SAT_EN
    localparam int EW = OUT_W;
`else
    localparam int EW = PSUM_W;
`endif

    typedef logic [N-1:0][EW-1:0] row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        overflow;
    logic [15:0] drop_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    row_t        exp_q[$];

    result_collector_if #(.N(N), .PSUM_W(PSUM_W), .EW(EW)) bus ();

    result_collector #(
        .N         (N),
        .PSUM_W    (PSUM_W),
        .OUT_W     (OUT_W),
        .ROW_DEPTH (ROW_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Monitor: every handshake pops one expected row.
    always @(negedge clk) begin
        if (!rst && bus.row_valid_o && bus.row_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL row_unexpected: got %h, none expected", bus.row_o);
            end else begin
                row_t e;
                e = exp_q.pop_front();
                if (bus.row_o !== e) begin
                    n_fail++;
                    $display("FAIL row_data: got %h, expected %h", bus.row_o, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic row_t mk_row(input int base);
        row_t r;
        for (int k = 0; k < N; k++) r[k] = EW'(base + k);
        return r;
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input int a, input int b);
        result_word_t w;
        w.lane0 = PSUM_W'(a);
        w.lane1 = PSUM_W'(b);
        bus.result_i       = w;
        bus.result_valid_i = 1'b1;
        align();
    endtask

    task automatic stop();
        bus.result_valid_i = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    task automatic send_row(input int base, input bit expect_it);
        if (expect_it) exp_q.push_back(mk_row(base));
        for (int w = 0; w < N / 2; w++) word(base + 2 * w, base + 2 * w + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        align();
        align();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) align();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        row_t sat_row;
        bus.result_i       = '0;
        bus.result_valid_i = 1'b0;
        bus.flush_i        = 1'b0;
        bus.row_ready_i    = 1'b0;
        rst                = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_valid", bus.row_valid_o, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        align();

        // Basic row with one-cycle latency and a single-cycle valid pulse.
        bus.row_ready_i = 1'b1;
        send_row(1, 1);
        stop();
        @(negedge clk);
        check("latency_valid", bus.row_valid_o, 1);
        align();
        @(negedge clk);
        check("valid_pulse", bus.row_valid_o, 0);
        check("basic_drained", exp_q.size(), 0);
        align();

        // Backpressure: third row dropped, first two retained in order.
        bus.row_ready_i = 1'b0;
        send_row(11, 1);
        send_row(21, 1);
        send_row(31, 0);
        stop();
        @(negedge clk);
        check("ovf_set", overflow, 1);
        check("drop_one", drop_cnt, 1);
        check("full_valid", bus.row_valid_o, 1);
        repeat (3) align();
        @(negedge clk);
        check("head_hold", (bus.row_o == mk_row(11)), 1);
        align();
        bus.row_ready_i = 1'b1;
        drain("drain_two");
        check("drop_after_drain", drop_cnt, 1);

        // Push on full with a same-cycle pop is not a drop.
        do_reset();
        bus.row_ready_i = 1'b0;
        send_row(41, 1);
        send_row(51, 1);
        exp_q.push_back(mk_row(61));
        word(61, 62);
        word(63, 64);
        word(65, 66);
        bus.row_ready_i = 1'b1;
        word(67, 68);
        stop();
        drain("drain_three");
        check("no_ovf", overflow, 0);
        check("no_drop", drop_cnt, 0);

        // Flush discards the partial row and the word arriving with it.
        word(91, 92);
        word(93, 94);
        bus.flush_i = 1'b1;
        word(95, 96);
        bus.flush_i = 1'b0;
        send_row(71, 1);
        stop();
        drain("flush_row");
        @(negedge clk);
        check("flush_idle", bus.row_valid_o, 0);
        check("flush_drop", drop_cnt, 0);
        align();

        // Saturation boundary values.
`ifdef RESULT_COLLECTOR_SAT_EN
        sat_row = {8'hFF, 8'h00, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F};
`else
        sat_row = {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FF7F, 32'h0000_0080,
                   32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_FED4, 32'h0000_012C};
`endif
        exp_q.push_back(sat_row);
        word(300, -300);
        word(127, -128);
        word(128, -129);
        word(0, -1);
        stop();
        drain("sat_row");

        // Reset mid-row with a queued row loses everything.
        bus.row_ready_i = 1'b0;
        send_row(81, 1);
        word(91, 92);
        word(93, 94);
        word(95, 96);
        stop();
        @(negedge clk);
        check("queued_valid", bus.row_valid_o, 1);
        align();
        rst = 1'b1;
        exp_q.delete();
        align();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", bus.row_valid_o, 0);
        check("rst_mid_drop", drop_cnt, 0);
        align();
        bus.row_ready_i = 1'b1;
        send_row(101, 1);
        stop();
        drain("post_rst_row");

        repeat (3) align();
        check("final_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
